// File: rtl/cordic_sequencer_if.sv
// Byte-level host/consumer handshakes plus the CORDIC datapath control/result bus.
// The sequencer connects through the slave modport; the host/datapath side uses master.
interface cordic_sequencer_if #(
    parameter int IDX_W = 4
);
    logic             cmd_valid;
    logic [7:0]       cmd_data;
    logic             cmd_ready;
    logic             dp_load;
    logic [15:0]      dp_angle;
    logic             dp_step;
    logic [IDX_W-1:0] dp_idx;
    logic [15:0]      dp_cos;
    logic [15:0]      dp_sin;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             busy;

    modport master (
        output cmd_valid, cmd_data, dp_cos, dp_sin, out_ready,
        input  cmd_ready, dp_load, dp_angle, dp_step, dp_idx, out_valid, out_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_data, dp_cos, dp_sin, out_ready,
        output cmd_ready, dp_load, dp_angle, dp_step, dp_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/cordic_sequencer.sv
// Control sequencer for a ROM-less CORDIC rotation datapath: gathers a 16-bit angle,
// drives ITERS iteration steps, then streams cos/sin back as four bytes.
module cordic_sequencer #(
    parameter int ITERS = 14,
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cordic_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, GET_HI, LOAD, RUN, CAPTURE, SEND} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERS - 1);

    state_t           state, state_nx;
    logic [15:0]      angle;
    logic [15:0]      res_cos;
    logic [15:0]      res_sin;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bcnt;
    logic             cmd_ready;
    logic             out_valid;
    logic             cmd_fire;
    logic             out_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // All control outputs are Moore decodes, so an async reset clears them at once.
    always_comb begin
        state_nx  = state;
        cmd_ready = (state == IDLE) || (state == GET_HI);
        out_valid = (state == SEND);
        cmd_fire  = cmd_ready && bus.cmd_valid;
        out_fire  = out_valid && bus.out_ready;
        case (state)
            IDLE:    if (cmd_fire) state_nx = GET_HI;
            GET_HI:  if (cmd_fire) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (idx == LAST_IDX) state_nx = CAPTURE;
            CAPTURE: state_nx = SEND;
            SEND:    if (out_fire && bcnt == 2'd3) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle   <= '0;
            res_cos <= '0;
            res_sin <= '0;
            idx     <= '0;
            bcnt    <= '0;
        end else begin
            case (state)
                IDLE:    if (cmd_fire) angle[7:0]  <= bus.cmd_data;
                GET_HI:  if (cmd_fire) angle[15:8] <= bus.cmd_data;
                LOAD:    idx <= '0;
                RUN:     if (idx != LAST_IDX) idx <= idx + 1'b1;
                CAPTURE: begin
                    res_cos <= bus.dp_cos;
                    res_sin <= bus.dp_sin;
                    bcnt    <= '0;
                end
                SEND:    if (out_fire) bcnt <= bcnt + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.out_data = '0;
        if (out_valid) begin
            case (bcnt)
                2'd0:    bus.out_data = res_cos[7:0];
                2'd1:    bus.out_data = res_cos[15:8];
                2'd2:    bus.out_data = res_sin[7:0];
                default: bus.out_data = res_sin[15:8];
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.out_valid = out_valid;
    assign bus.dp_load   = (state == LOAD);
    assign bus.dp_step   = (state == RUN);
    assign bus.dp_idx    = (state == RUN) ? idx : '0;
    assign bus.dp_angle  = angle;
    assign bus.busy      = (state == LOAD) || (state == RUN) ||
                           (state == CAPTURE) || (state == SEND);
endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: a datapath stand-in counts loads/steps and produces a
// result only after exactly ITERS steps; byte streams are checked against a reference.
module tb_cordic_sequencer;
    localparam int ITERS = 14;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cordic_sequencer_if #(.IDX_W(IDX_W)) bus ();

    cordic_sequencer #(.ITERS(ITERS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_cos(input logic [15:0] a);
        return 16'h26DD ^ (a * 16'd5);
    endfunction

    function automatic logic [15:0] model_sin(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ (a >> 3);
    endfunction

    // Datapath stand-in: result is only meaningful after a load followed by ITERS steps.
    logic [15:0] st_ang = '0;
    int          st_steps = 0;
    int          loads = 0;
    int          idx_bad = 0;

    always @(posedge clk) begin
        if (bus.dp_load) begin
            st_ang   <= bus.dp_angle;
            st_steps <= 0;
            loads    <= loads + 1;
        end else if (bus.dp_step) begin
            if (int'(bus.dp_idx) != st_steps) idx_bad <= idx_bad + 1;
            st_steps <= st_steps + 1;
        end
        if (!bus.dp_step && bus.dp_idx != '0) idx_bad <= idx_bad + 1;
    end

    assign bus.dp_cos = (st_steps == ITERS) ? model_cos(st_ang) : 16'hDEAD;
    assign bus.dp_sin = (st_steps == ITERS) ? model_sin(st_ang) : 16'hBEEF;

    // Driving helpers: entered and left on a negedge.
    task automatic send_byte(input logic [7:0] b, output bit ok, output int waited);
        waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        while (!bus.cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        ok = bus.cmd_ready;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic recv_n(input int n, input bit rnd, output logic [31:0] got, output bit ok);
        int k = 0;
        int cyc = 0;
        got = '0;
        while (k < n && cyc < 2000) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                got[8*k +: 8] = bus.out_data;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b1;
        ok = (k == n);
    endtask

    task automatic send_angle(input logic [15:0] a, output bit ok);
        bit ok1, ok2;
        int w;
        send_byte(a[7:0], ok1, w);
        send_byte(a[15:8], ok2, w);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.out_valid !== 1'b0 || bus.dp_step !== 1'b0 || bus.dp_load !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl got ov=%b st=%b ld=%b want 0", bus.out_valid, bus.dp_step, bus.dp_load); end
        total++; if (bus.dp_angle !== 16'h0 || bus.dp_idx !== '0 || bus.out_data !== 8'h0) begin
            bad++; $display("FAIL reset_data got ang=%h idx=%h od=%h want 0", bus.dp_angle, bus.dp_idx, bus.out_data); end
    endtask

    task automatic test_rotate0();
        bit ok;
        logic [31:0] got;
        int l0 = loads;
        int i0 = idx_bad;
        send_angle(16'h0000, ok);
        recv_n(4, 1'b0, got, ok);
        total++; if (!ok) begin bad++; $display("FAIL rotate0_timeout got=0 want=1"); end
        total++; if (got !== 32'h0000_26DD) begin bad++; $display("FAIL rotate0_bytes got=%h want=000026dd", got); end
        total++; if (loads - l0 != 1) begin bad++; $display("FAIL rotate0_loads got=%0d want=1", loads - l0); end
        total++; if (st_steps != ITERS || idx_bad != i0) begin
            bad++; $display("FAIL rotate0_steps got=%0d idxerr=%0d want=%0d idxerr=0", st_steps, idx_bad - i0, ITERS); end
    endtask

    task automatic test_latency();
        bit ok;
        int w, cyc;
        bit busy_drop = 0;
        logic [31:0] got;
        logic [15:0] a = 16'h3243;
        send_byte(a[7:0], ok, w);
        send_byte(a[15:8], ok, w);
        total++; if (bus.dp_load !== 1'b1) begin bad++; $display("FAIL latency_load got=%b want=1", bus.dp_load); end
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            if (!bus.busy) busy_drop = 1;
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc != ITERS + 2) begin bad++; $display("FAIL latency_edges got=%0d want=%0d", cyc, ITERS + 2); end
        total++; if (busy_drop || !bus.busy) begin bad++; $display("FAIL latency_busy got=drop want=held"); end
        recv_n(4, 1'b0, got, ok);
        total++; if (got !== {model_sin(a), model_cos(a)}) begin
            bad++; $display("FAIL latency_bytes got=%h want=%h", got, {model_sin(a), model_cos(a)}); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc = 0;
        logic [31:0] got;
        logic [7:0] b0;
        send_angle(16'h0000, ok);
        bus.out_ready = 1'b0;
        while (!bus.out_valid && cyc < 100) begin @(negedge clk); cyc++; end
        bus.out_ready = 1'b1;
        b0 = bus.out_data;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (b0 !== 8'hDD) begin bad++; $display("FAIL bp_byte0 got=%h want=dd", b0); end
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h26) begin
                bad++; $display("FAIL bp_hold[%0d] got ov=%b od=%h want ov=1 od=26", i, bus.out_valid, bus.out_data); end
            @(negedge clk);
        end
        recv_n(3, 1'b0, got, ok);
        total++; if (got[23:0] !== 24'h00_0026) begin bad++; $display("FAIL bp_rest got=%h want=000026", got[23:0]); end
        total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL bp_end got ov=%b busy=%b want 0 0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int cyc = 0;
        logic [31:0] got;
        logic [15:0] a = 16'($urandom);
        logic [15:0] b = 16'($urandom);
        send_angle(a, ok);
        while (!(bus.dp_step && bus.dp_idx == 4'd3) && cyc < 100) begin @(negedge clk); cyc++; end
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.cmd_ready !== 1'b0 || bus.dp_angle !== a) begin
                bad++; $display("FAIL ignore[%0d] got rdy=%b ang=%h want rdy=0 ang=%h", i, bus.cmd_ready, bus.dp_angle, a); end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        recv_n(4, 1'b0, got, ok);
        total++; if (got !== {model_sin(a), model_cos(a)}) begin
            bad++; $display("FAIL ignore_bytes got=%h want=%h", got, {model_sin(a), model_cos(a)}); end
        send_angle(b, ok);
        recv_n(4, 1'b0, got, ok);
        total++; if (got !== {model_sin(b), model_cos(b)}) begin
            bad++; $display("FAIL ignore_next got=%h want=%h", got, {model_sin(b), model_cos(b)}); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int cyc = 0;
        int l0;
        logic [31:0] got;
        logic [15:0] a = 16'h5A5A;
        send_angle(16'h7777, ok);
        while (!(bus.dp_step && bus.dp_idx == 4'd7) && cyc < 100) begin @(negedge clk); cyc++; end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.dp_step !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.dp_idx !== '0) begin
            bad++; $display("FAIL rst_mid got st=%b rdy=%b busy=%b idx=%h want 0 1 0 0", bus.dp_step, bus.cmd_ready, bus.busy, bus.dp_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        l0 = loads;
        send_angle(a, ok);
        recv_n(4, 1'b1, got, ok);
        total++; if (st_steps != ITERS || loads - l0 != 1) begin
            bad++; $display("FAIL rst_after_steps got=%0d loads=%0d want=%0d loads=1", st_steps, loads - l0, ITERS); end
        total++; if (got !== {model_sin(a), model_cos(a)}) begin
            bad++; $display("FAIL rst_after_bytes got=%h want=%h", got, {model_sin(a), model_cos(a)}); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int w;
        logic [31:0] got;
        logic [15:0] a = 16'h1234;
        logic [15:0] b = 16'h1000;
        send_angle(a, ok);
        recv_n(4, 1'b0, got, ok);
        total++; if (got !== {model_sin(a), model_cos(a)}) begin
            bad++; $display("FAIL b2b_first got=%h want=%h", got, {model_sin(a), model_cos(a)}); end
        send_byte(b[7:0], ok, w);
        total++; if (w != 0) begin bad++; $display("FAIL b2b_wait got=%0d want=0", w); end
        send_byte(b[15:8], ok, w);
        total++; if (bus.dp_angle !== b) begin bad++; $display("FAIL b2b_angle got=%h want=%h", bus.dp_angle, b); end
        recv_n(4, 1'b0, got, ok);
        total++; if (got !== {model_sin(b), model_cos(b)}) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", got, {model_sin(b), model_cos(b)}); end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] got;
        logic [15:0] a;
        int i0;
        for (int n = 0; n < 8; n++) begin
            a = 16'($urandom);
            i0 = idx_bad;
            send_angle(a, ok);
            recv_n(4, 1'b1, got, ok);
            total++; if (!ok || got !== {model_sin(a), model_cos(a)}) begin
                bad++; $display("FAIL rand[%0d] got=%h want=%h", n, got, {model_sin(a), model_cos(a)}); end
            total++; if (st_steps != ITERS || idx_bad != i0) begin
                bad++; $display("FAIL rand_steps[%0d] got=%0d idxerr=%0d want=%0d", n, st_steps, idx_bad - i0, ITERS); end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_rotate0();
        test_latency();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
